// File: rtl/updown_counter.sv
// WIDTH-bit up/down counter with asynchronous active-low clear.
// Define UPDOWN_COUNTER_RIPPLE_EN for the ripple-chain build; default is fully synchronous.
module updown_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ud,
  output logic [WIDTH-1:0] count
);

`ifdef UPDOWN_COUNTER_RIPPLE_EN

  logic             dir;
  logic             bit0;
  logic [WIDTH-1:0] q;

  // Direction is retimed to the falling clk edge so it is stable while the chain ripples
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) dir <= 1'b1;
    else        dir <= ud;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bit0 <= 1'b0;
    else        bit0 <= ~bit0;
  end

  assign q[0] = bit0;

  // Each stage uses two fixed-clock toggle flops (one per edge of the previous bit) and
  // XORs them, so the direction select is a data enable and never switches a clock.
  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    logic up_t;
    logic dn_t;

    always_ff @(negedge q[i-1] or negedge reset) begin
      if (!reset)   up_t <= 1'b0;
      else if (dir) up_t <= ~up_t;
    end

    always_ff @(posedge q[i-1] or negedge reset) begin
      if (!reset)    dn_t <= 1'b0;
      else if (!dir) dn_t <= ~dn_t;
    end

    assign q[i] = up_t ^ dn_t;
  end

  assign count = q;

`else

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  count <= '0;
    else if (ud) count <= count + WIDTH'(1);
    else         count <= count - WIDTH'(1);
  end

`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (either build).
`timescale 1ns/100ps
module tb_updown_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ud = 1'b1;
  logic [WIDTH-1:0] count;

  int checks = 0;
  int passed = 0;

  updown_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ud    (ud),
    .count (count)
  );

  always #3 clk = ~clk;

  // Advance one rising edge and settle 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ud    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== 8'd0) $display("FAIL reset_hold[%0d]: got %0d expected 0", i, count);
      else passed++;
    end
  endtask

  task automatic test_up();
    logic [WIDTH-1:0] exp_v [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    reset = 1'b1;
    ud    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (count !== exp_v[i]) $display("FAIL up[%0d]: got %0d expected %0d", i, count, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_direction();
    logic [WIDTH-1:0] exp_v [6] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
    #1;
    ud = 1'b0;
    #0.5;
    checks++;
    if (count !== 8'd4) $display("FAIL dir_no_glitch: got %0d expected 4", count);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (count !== exp_v[i]) $display("FAIL down[%0d]: got %0d expected %0d", i, count, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp_v [3] = '{8'd255, 8'd0, 8'd1};
    ud = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== exp_v[i]) $display("FAIL wrap_up[%0d]: got %0d expected %0d", i, count, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    ud = 1'b1;
    for (int i = 0; i < 36; i++) step();
    checks++;
    if (count !== 8'd37) $display("FAIL reach_37: got %0d expected 37", count);
    else passed++;
    #1;
    reset = 1'b0;
    #0.5;
    checks++;
    if (count !== 8'd0) $display("FAIL async_clear: got %0d expected 0", count);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 8'd0) $display("FAIL clear_hold[%0d]: got %0d expected 0", i, count);
      else passed++;
    end
    reset = 1'b1;
    ud    = 1'b1;
    step();
    checks++;
    if (count !== 8'd1) $display("FAIL first_after_release: got %0d expected 1", count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic             dir_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] exp_v [5] = '{8'd0, 8'd255, 8'd0, 8'd1, 8'd0};
    for (int i = 0; i < 5; i++) begin
      ud = dir_v[i];
      step();
      checks++;
      if (count !== exp_v[i]) $display("FAIL b2b[%0d]: got %0d expected %0d", i, count, exp_v[i]);
      else passed++;
    end
  endtask

  initial begin
    #0.5;
    checks++;
    if (count !== 8'd0) $display("FAIL reset_initial: got %0d expected 0", count);
    else passed++;
    test_reset();
    test_up();
    test_direction();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
